// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing the 8-bit memory port between fetch, load and store.
// Multi-byte transfers are sequenced one byte per cycle, little-endian.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_size,
    output logic        ld_done,
    output logic [31:0] ld_data,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic        st_done,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [1:0]    state;
    logic          src_if;
    logic [31:0]   base;
    logic [2:0]    nbytes;
    logic [2:0]    cnt;
    logic [2:0]    rcv;
    logic          a_valid;
    logic          d_valid;
    logic [31:0]   assemble;
    logic [SW-1:0] starve;

    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        case (s)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    logic        starved;
    logic        grant_st;
    logic        grant_if;
    logic        grant_ld;
    logic        io_stall;
    logic [7:0]  st_byte;
    logic [31:0] asm_next;

    always_comb begin
        starved  = (starve >= SW'(STARVE_LIMIT));
        grant_st = st_req;
        grant_if = !st_req && !rollback && if_req && (starved || !ld_req);
        grant_ld = !st_req && !rollback && ld_req && !grant_if;
        // The store address is held stable for the whole transfer, so it is valid in IDLE and WRITE.
        io_stall = (st_addr[17:16] == 2'b11) && io_buffer_full;
        st_byte  = st_data[{cnt[1:0], 3'b000} +: 8];
        asm_next = assemble;
        asm_next[{rcv[1:0], 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            src_if   <= 1'b0;
            base     <= 32'd0;
            nbytes   <= 3'd0;
            cnt      <= 3'd0;
            rcv      <= 3'd0;
            a_valid  <= 1'b0;
            d_valid  <= 1'b0;
            assemble <= 32'd0;
            starve   <= '0;
            if_done  <= 1'b0;
            ld_done  <= 1'b0;
            st_done  <= 1'b0;
            if_data  <= 32'd0;
            ld_data  <= 32'd0;
            mem_a    <= 32'd0;
            mem_wr   <= 1'b0;
            mem_dout <= 8'd0;
        end else if (!rdy) begin
            mem_wr <= 1'b0;
        end else begin
            if_done <= 1'b0;
            ld_done <= 1'b0;
            st_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    mem_a    <= 32'd0;
                    mem_wr   <= 1'b0;
                    mem_dout <= 8'd0;
                    a_valid  <= 1'b0;
                    d_valid  <= 1'b0;
                    cnt      <= 3'd0;
                    rcv      <= 3'd0;
                    if (grant_st) begin
                        src_if <= 1'b0;
                        base   <= st_addr;
                        nbytes <= size_bytes(st_size);
                        state  <= S_WRITE;
                        if (!io_stall) begin
                            mem_wr   <= 1'b1;
                            mem_a    <= st_addr;
                            mem_dout <= st_data[7:0];
                            cnt      <= 3'd1;
                        end
                    end else if (grant_if || grant_ld) begin
                        src_if   <= grant_if;
                        base     <= grant_if ? if_addr : ld_addr;
                        nbytes   <= grant_if ? 3'd4 : size_bytes(ld_size);
                        mem_a    <= grant_if ? if_addr : ld_addr;
                        a_valid  <= 1'b1;
                        cnt      <= 3'd1;
                        assemble <= 32'd0;
                        state    <= S_READ;
                    end
                    if (grant_if) begin
                        starve <= '0;
                    end else if ((grant_st || grant_ld) && if_req && !starved) begin
                        starve <= starve + 1'b1;
                    end
                end
                S_READ: begin
                    if (rollback) begin
                        state   <= S_IDLE;
                        mem_a   <= 32'd0;
                        a_valid <= 1'b0;
                        d_valid <= 1'b0;
                        cnt     <= 3'd0;
                        rcv     <= 3'd0;
                    end else begin
                        // Data returned now belongs to the byte presented one cycle earlier.
                        d_valid <= a_valid;
                        if (cnt < nbytes) begin
                            mem_a   <= base + {29'd0, cnt};
                            cnt     <= cnt + 3'd1;
                            a_valid <= 1'b1;
                        end else begin
                            mem_a   <= 32'd0;
                            a_valid <= 1'b0;
                        end
                        if (d_valid) begin
                            assemble <= asm_next;
                            rcv      <= rcv + 3'd1;
                            if (rcv == nbytes - 3'd1) begin
                                state <= S_DONE;
                                if (src_if) begin
                                    if_done <= 1'b1;
                                    if_data <= asm_next;
                                end else begin
                                    ld_done <= 1'b1;
                                    ld_data <= asm_next;
                                end
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (cnt == nbytes) begin
                        state    <= S_DONE;
                        st_done  <= 1'b1;
                        mem_wr   <= 1'b0;
                        mem_a    <= 32'd0;
                        mem_dout <= 8'd0;
                    end else if (io_stall) begin
                        mem_wr   <= 1'b0;
                        mem_a    <= 32'd0;
                        mem_dout <= 8'd0;
                    end else begin
                        mem_wr   <= 1'b1;
                        mem_a    <= base + {29'd0, cnt};
                        mem_dout <= st_byte;
                        cnt      <= cnt + 3'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 3'd0;
                    rcv   <= 3'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a byte-array memory and
// a reference image computed from transaction semantics.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        rollback = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_done;
    logic [31:0] if_data;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = 32'd0;
    logic [1:0]  ld_size = 2'd0;
    logic        ld_done;
    logic [31:0] ld_data;
    logic        st_req = 1'b0;
    logic [31:0] st_addr = 32'd0;
    logic [1:0]  st_size = 2'd0;
    logic [31:0] st_data = 32'd0;
    logic        st_done;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_done(ld_done), .ld_data(ld_data),
        .st_req(st_req), .st_addr(st_addr), .st_size(st_size), .st_data(st_data), .st_done(st_done),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // Memory with one-cycle read latency; unwritten bytes come from a fixed address hash.
    logic [7:0] mem     [0:65535];
    logic       wflag   [0:65535];
    logic [7:0] ref_mem [0:65535];
    int         wr_total = 0;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_a[15:0]]   <= mem_dout;
            wflag[mem_a[15:0]] <= 1'b1;
            wr_total           <= wr_total + 1;
        end
        mem_din <= (wflag[mem_a[15:0]] === 1'b1) ? mem[mem_a[15:0]] : init_byte(mem_a[15:0]);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
        logic [31:0] v;
        logic [31:0] a;
        v = 32'd0;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            v = v | (32'(ref_mem[a[15:0]]) << (8 * k));
        end
        return v;
    endfunction

    // Entered at the negedge of an IDLE cycle (cycle 0); returns at negedge of cycle N+3.
    task automatic read_xact(input int src, input logic [31:0] addr, input logic [1:0] size);
        int          n;
        logic [31:0] exp;
        logic [31:0] a;
        n   = (src == 0) ? 4 : nbytes(size);
        exp = ref_read(addr, n);
        if (src == 0) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            ld_req = 1'b1; ld_addr = addr; ld_size = size;
        end
        for (int c = 1; c <= n + 2; c++) begin
            @(negedge clk);
            a = addr + 32'(c - 1);
            check("rd_mem_a", mem_a, (c <= n) ? a : 32'd0);
            check("rd_mem_wr", 32'(mem_wr), 32'd0);
            check(src == 0 ? "if_done" : "ld_done", 32'(src == 0 ? if_done : ld_done), 32'(c == n + 2));
            check("rd_other_done", 32'((src == 0 ? ld_done : if_done) | st_done), 32'd0);
            if (c == n + 2) check(src == 0 ? "if_data" : "ld_data", src == 0 ? if_data : ld_data, exp);
        end
        @(negedge clk);
        if (src == 0) if_req = 1'b0; else ld_req = 1'b0;
        check("rd_done_pulse", 32'(src == 0 ? if_done : ld_done), 32'd0);
        check("rd_data_hold", src == 0 ? if_data : ld_data, exp);
        $display("read  src=%0d addr=%h bytes=%0d expect=%h", src, addr, n, exp);
    endtask

    task automatic write_xact(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                              input int stall, input logic noise);
        int          n;
        int          k;
        logic        exp_wr;
        logic [31:0] exp_a;
        logic [31:0] a;
        n = nbytes(size);
        st_req = 1'b1; st_addr = addr; st_size = size; st_data = data;
        io_buffer_full = (stall > 0) || noise;
        for (int c = 1; c <= stall + n + 1; c++) begin
            @(negedge clk);
            io_buffer_full = (c < stall) || noise;
            exp_wr = (c > stall) && (c <= stall + n);
            k      = c - stall - 1;
            exp_a  = exp_wr ? addr + 32'(k) : 32'd0;
            check("wr_mem_wr", 32'(mem_wr), 32'(exp_wr));
            check("wr_mem_a", mem_a, exp_a);
            if (exp_wr) check("wr_mem_dout", 32'(mem_dout), 32'(data[8*k +: 8]));
            check("st_done", 32'(st_done), 32'(c == stall + n + 1));
            check("wr_other_done", 32'(if_done | ld_done), 32'd0);
        end
        for (int j = 0; j < n; j++) begin
            a = addr + 32'(j);
            ref_mem[a[15:0]] = data[8*j +: 8];
        end
        @(negedge clk);
        st_req = 1'b0;
        io_buffer_full = 1'b0;
        check("st_done_pulse", 32'(st_done), 32'd0);
        $display("write addr=%h bytes=%0d data=%h stall=%0d", addr, n, data, stall);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          diffs;
        int          base_wr;
        int          kind;
        logic [31:0] ra;
        logic [31:0] rd;
        logic [7:0]  mb;

        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));

        // Reset state
        @(negedge clk);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_dones", 32'({if_done, ld_done, st_done}), 32'd0);
        check("rst_if_data", if_data, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Preload through the DUT: 13 05 00 00 at 0x100, FF 80 at 0x2002
        write_xact(32'h0000_0100, 2'd2, 32'h0000_0513, 0, 1'b0);
        write_xact(32'h0000_2002, 2'd1, 32'h0000_80FF, 0, 1'b0);

        // Word fetch, then a back-to-back fetch granted in the cycle after DONE
        read_xact(0, 32'h0000_0100, 2'd0);
        check("fetch_const", if_data, 32'h0000_0513);
        read_xact(0, 32'h0000_0104, 2'd0);

        // Store beats a simultaneous fetch; fetch follows in cycle 3
        if_req = 1'b1; if_addr = 32'h0000_0100;
        write_xact(32'h0000_1000, 2'd0, 32'h0000_00AB, 0, 1'b0);
        read_xact(0, 32'h0000_0100, 2'd0);

        // IO stall for three launch attempts, and io_buffer_full ignored outside IO space
        write_xact(32'h0003_0000, 2'd0, 32'h0000_0042, 3, 1'b0);
        write_xact(32'h0000_1100, 2'd1, 32'h0000_BEEF, 0, 1'b1);

        // A committed store is granted and completes under rollback
        rollback = 1'b1;
        write_xact(32'h0000_1200, 2'd2, 32'hCAFE_F00D, 0, 1'b0);
        rollback = 1'b0;

        // Rollback in IDLE blocks a load grant
        ld_req = 1'b1; ld_addr = 32'h0000_0700; ld_size = 2'd0; rollback = 1'b1;
        @(negedge clk);
        rollback = 1'b0;
        check("rb_idle_mem_a", mem_a, 32'd0);
        read_xact(1, 32'h0000_0700, 2'd0);

        // Rollback aborts a word load in cycle 2
        ld_req = 1'b1; ld_addr = 32'h0000_2000; ld_size = 2'd2;
        @(negedge clk);
        check("rb_c1_mem_a", mem_a, 32'h0000_2000);
        @(negedge clk);
        check("rb_c2_mem_a", mem_a, 32'h0000_2001);
        rollback = 1'b1;
        @(negedge clk);
        rollback = 1'b0;
        ld_req = 1'b0;
        check("rb_c3_mem_a", mem_a, 32'd0);
        check("rb_c3_ld_done", 32'(ld_done), 32'd0);
        check("rb_c3_mem_wr", 32'(mem_wr), 32'd0);
        read_xact(1, 32'h0000_2002, 2'd1);
        check("half_load_const", ld_data, 32'h0000_80FF);

        // rdy low for two cycles mid word-store
        base_wr = wr_total;
        st_req = 1'b1; st_addr = 32'h0000_3000; st_size = 2'd2; st_data = 32'h1122_3344;
        @(negedge clk);
        check("rdy_c1_wr", 32'(mem_wr), 32'd1);
        check("rdy_c1_a", mem_a, 32'h0000_3000);
        rdy = 1'b0;
        @(negedge clk);
        check("rdy_pause_wr", 32'(mem_wr), 32'd0);
        check("rdy_pause_a", mem_a, 32'h0000_3000);
        @(negedge clk);
        check("rdy_pause2_wr", 32'(mem_wr), 32'd0);
        check("rdy_pause2_done", 32'(st_done), 32'd0);
        rdy = 1'b1;
        for (int c = 4; c <= 6; c++) begin
            @(negedge clk);
            check("rdy_resume_wr", 32'(mem_wr), 32'd1);
            check("rdy_resume_a", mem_a, 32'h0000_3000 + 32'(c - 3));
            check("rdy_resume_dout", 32'(mem_dout), 32'(st_data[8*(c-3) +: 8]));
        end
        @(negedge clk);
        check("rdy_st_done", 32'(st_done), 32'd1);
        st_req = 1'b0;
        for (int j = 0; j < 4; j++) ref_mem[16'h3000 + 16'(j)] = st_data[8*j +: 8];
        @(negedge clk);
        check("rdy_write_count", 32'(wr_total - base_wr), 32'd4);
        $display("write addr=00003000 bytes=4 data=11223344 with rdy pause");

        // Starvation: fetch wins after 8 lost grants, twice in a row
        if_req = 1'b1; if_addr = 32'h0000_0500;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) read_xact(1, 32'h0000_0600 + 32'(i + 8 * r), 2'd0);
            ld_req = 1'b1; ld_addr = 32'h0000_0680;
            read_xact(0, 32'h0000_0500 + 32'(4 * r), 2'd0);
            if_req = 1'b1;
        end
        ld_req = 1'b0; if_req = 1'b0;

        // Address wrap across 0xFFFFFFFF
        read_xact(1, 32'hFFFF_FFFF, 2'd1);

        // Randomized mix
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 2));
            ra   = 32'($urandom_range(0, 32'h0000_FFFF));
            rd   = $urandom;
            if (kind == 0) read_xact(0, ra, 2'd0);
            else if (kind == 1) read_xact(1, ra, 2'($urandom_range(0, 3)));
            else write_xact(ra, 2'($urandom_range(0, 3)), rd, 0, 1'($urandom_range(0, 1)));
        end

        // Reset mid-read clears every output at once
        if_req = 1'b1; if_addr = 32'h0000_0400;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_mem_a", mem_a, 32'd0);
        check("arst_mem_wr", 32'(mem_wr), 32'd0);
        check("arst_mem_dout", 32'(mem_dout), 32'd0);
        check("arst_dones", 32'({if_done, ld_done, st_done}), 32'd0);
        check("arst_if_data", if_data, 32'd0);
        check("arst_ld_data", ld_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        if_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("arst_no_done", 32'(if_done), 32'd0);
            check("arst_idle_a", mem_a, 32'd0);
        end
        $display("reset mid-read addr=00000400");

        // Memory image against the reference
        diffs = 0;
        for (int i = 0; i < 65536; i++) begin
            mb = (wflag[i] === 1'b1) ? mem[i] : init_byte(16'(i));
            if (mb !== ref_mem[i]) diffs++;
        end
        check("mem_image_diffs", 32'(diffs), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Byte-serial memory bus arbiter that shares the single 8-bit memory port among three requesters: instruction-cache refill (word reads), LSB loads (1/2/4-byte reads) and ROB-committed stores (1/2/4-byte writes). It sequences multi-byte transfers one byte per cycle, little-endian. It honours the 1-cycle read latency of memory, stalls UART writes on `io_buffer_full`, and discards speculative traffic on `rollback`. It sits between icache/lsb/rob and the top-level `mem_*` pins.

## Interface
- `STARVE_LIMIT`, 8: consecutive cycles a pending fetch may be passed over before it is forced to win arbitration once.

- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `rdy`  in  1  global ready; low freezes the block
- `rollback`  in  1  flush of speculative state
- `if_req`  in  1  fetch request; `if_addr`  in  32  word address
- `if_done`  out  1  one-cycle completion; `if_data`  out  32  fetched word
- `ld_req`  in  1  load request; `ld_addr`  in  32; `ld_size`  in  2  0=byte, 1=half, 2=word
- `ld_done`  out  1; `ld_data`  out  32  zero-extended load data
- `st_req`  in  1; `st_addr`  in  32; `st_size`  in  2; `st_data`  in  32
- `st_done`  out  1  store fully written
- `mem_din`  in  8; `mem_dout`  out  8; `mem_a`  out  32; `mem_wr`  out  1  1=write
- `io_buffer_full`  in  1  UART tx buffer full

## Operation
- **FSM states:**
  - IDLE: samples requests.
  - READ: launches bytes and captures read data.
  - WRITE: launches store bytes.
  - DONE: pulses `*_done` for one cycle, then returns to IDLE.
- **Priority in IDLE:** st > ld > if.
  - A starve counter increments on each IDLE grant cycle in which `if_req` is high but fetch loses.
  - At `STARVE_LIMIT` the next grant goes to fetch, unless a store is pending. The counter clears on a fetch grant.
- **Byte count N:** fetch = 4. Load/store = 1, 2 or 4 per size code (size 3 treated as 4).
- **Address generation:** byte k uses `addr+k`, with 32-bit wrap. Bytes are assembled little-endian; byte k fills bits [8k+7:8k].
- **Request handshake:**
  - The requester holds req and its fields stable from assertion until it sees done.
  - It drops req in the cycle after done.
  - Done is never asserted without a grant.
- **IO write stall:** if `st_addr[17:16]==2'b11` and `io_buffer_full` is high at the edge that would launch a byte, that byte is not launched (`mem_wr=0`, `mem_a=0`) and is retried every cycle.
- **Rollback:**
  - In READ for fetch or load: the transfer is aborted. The FSM goes to IDLE next cycle with no done.
  - In IDLE: rollback blocks fetch/load grants that cycle; a store may still be granted.
  - WRITE is never aborted: committed stores always complete and raise `st_done`.
- **rdy low:** state, counters and outputs hold, except `mem_wr`, which is forced 0 so no byte is written twice. Sequencing resumes exactly where it stopped.
- **Reset (async, `rst`=0):**
  - FSM→IDLE, starve counter 0.
  - `mem_wr`=0, `mem_a`=0, `mem_dout`=0.
  - All done=0, `if_data`=`ld_data`=0.
  - A reset mid-store leaves memory partially written; this is accepted.
- **Inactive cycles:** when idle or stalled, `mem_a`=0 and `mem_wr`=0.

## Timing
- All outputs are registered.
- Cycle 0 is the IDLE cycle in which a request is granted.
- **Read of N bytes:**
  - `mem_a` = byte addresses in cycles 1..N.
  - `mem_din` is captured in cycles 2..N+1.
  - `*_done` and data are valid in cycle N+2 (DONE state).
- **Write of N bytes:**
  - `mem_wr`=1 with `mem_a`/`mem_dout` in cycles 1..N, plus any IO stall cycles.
  - `st_done` is asserted the cycle after the last byte.
- **Back-to-back transfers:** earliest next grant is sampled the cycle after DONE. A word fetch occupies 7 cycles grant-to-regrant.
- `if_data`/`ld_data` hold their value after done until the next completion of the same requester.

## Test plan
- **Fetch word:** fetch 0x100, memory bytes 13 05 00 00 → `mem_a` 0x100..0x103 in cycles 1..4, `mem_wr`=0; `if_done`=1 in cycle 6 with `if_data`=0x00000513.
- **Store beats fetch:** `st_req` (0x1000, size 0, data 0xAB) and `if_req` both high in cycle 0 → cycle 1 `mem_wr`=1, `mem_a`=0x1000, `mem_dout`=0xAB; `st_done` in cycle 2; fetch granted in cycle 3.
- **IO stall:** store byte to 0x30000 while `io_buffer_full`=1 for cycles 1–3 → `mem_wr`=0 in cycles 1–3, write issued in cycle 4, `st_done` in cycle 5.
- **Rollback aborts load:** word load at 0x2000, `rollback` in cycle 2 → no `ld_done`, `mem_wr` stays 0, FSM in IDLE in cycle 3; a later half-load of 0x2002 (bytes FF 80) gives `ld_data`=0x000080FF.
- **Starvation:** `ld_req` held continuously (new request after each done) with `if_req` held → fetch granted after 8 lost IDLE grant cycles; counter returns to 0.
- **rdy low:** `rdy` low for 2 cycles mid word-store → `mem_wr`=0 during the pause, all 4 bytes written exactly once.
- **Reset mid-read:** asserting `rst` mid-read → all outputs 0 immediately, no done.
